seq_shift_unit: RTL and testbench
=================================

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=2).
REQ-002 SHALL have parameter SHAMT_W, default 3, shift-amount field width; max shift = 2^SHAMT_W-1.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request pulse, sampled in IDLE only.
REQ-006 SHALL have port din  input  WIDTH  operand captured on accepted start.
REQ-007 SHALL have port mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; captured on accepted start.
REQ-008 SHALL have port shamt  input  SHAMT_W  shift count, captured on accepted start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port dout  output  WIDTH  working/result register.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE, start=1: SHALL load dout<=din, latch mode, counter<=shamt; next state SHIFT if shamt!=0, else DONE.
REQ-014 SHIFT: SHALL shift dout by exactly one bit per cycle, decrement counter, go to DONE on the edge where counter goes 1->0.
REQ-015 Per step: LSL zero-fill LSB; LSR zero-fill MSB; ASR replicate MSB; ROR old LSB into MSB.
REQ-016 DONE: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-017 Latency: start sampled at edge N SHALL give done=1 in cycle N+1+shamt (shamt=0 -> N+1).
REQ-018 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE; done SHALL be 1 only in DONE.
REQ-019 start while busy=1 (incl. DONE cycle) SHALL be ignored, not queued.
REQ-020 dout SHALL show intermediate values during SHIFT and hold the final result in IDLE until the next accepted start.
REQ-021 din/mode/shamt changes after acceptance SHALL not affect the running operation.
REQ-022 No arithmetic widening: bits shifted out SHALL be discarded (except ROR wrap).

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, dout=0, counter=0, busy=0, done=0, regardless of clock.
REQ-024 Reset mid-operation SHALL abort it with no done pulse; first start after release SHALL behave normally.

Configuration
REQ-025 Macro SEQ_SHIFT_ROTATE_EN defined: mode 11 SHALL perform ROR per REQ-015.
REQ-026 Macro undefined: rotate logic SHALL be absent and mode 11 SHALL behave exactly as LSR (01).

Verification (WIDTH=8, SHAMT_W=3)
REQ-027 LSL din=8'h06 shamt=3 -> dout=8'h30, done in cycle start+4, busy high cycles start+1..start+4.
REQ-028 ASR din=8'h90 shamt=2 -> dout=8'hE4; LSR same input -> 8'h24; LSL din=8'hFF shamt=7 -> 8'h80.
REQ-029 Any mode, din=8'hA5 shamt=0 -> dout=8'hA5, done in cycle start+1.
REQ-030 mode=11 din=8'h81 shamt=1 -> 8'hC0 with SEQ_SHIFT_ROTATE_EN, 8'h40 without.
REQ-031 start pulsed with new din during SHIFT and during DONE -> ignored, first result unchanged, no extra done.
REQ-032 rst_n low mid-SHIFT (shamt=5, after 2 steps) -> dout=0, busy=0, done=0 immediately; no done; next start LSL 8'h01 shamt=1 -> 8'h02.

Source files
------------

// File: rtl/seq_shift_unit.sv
// Sequential barrel-free shifter: shifts one bit per clock (LSL/LSR/ASR/ROR).
// Define SEQ_SHIFT_ROTATE_EN to enable ROR for mode 11; otherwise mode 11 acts as LSR.
module seq_shift_unit #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   din,
   input  logic [1:0]         mode,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   dout
);

   localparam logic [1:0] MODE_LSL = 2'b00;
   localparam logic [1:0] MODE_LSR = 2'b01;
   localparam logic [1:0] MODE_ASR = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   state_e               state_q, state_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]           mode_q, mode_d;
   logic [WIDTH-1:0]     dout_q, dout_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   // Single-bit step of the selected shift; shifted-out bits are dropped.
   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                   input logic [1:0]       m);
      logic [WIDTH-1:0] r;
      r = v;
      case (m)
         MODE_LSL: r = {v[WIDTH-2:0], 1'b0};
         MODE_LSR: r = {1'b0, v[WIDTH-1:1]};
         MODE_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
         MODE_ROR: begin
`ifdef SEQ_SHIFT_ROTATE_EN
            r = {v[0], v[WIDTH-1:1]};
`else
            r = {1'b0, v[WIDTH-1:1]};
`endif
         end
         default:  r = v;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mode_q  <= '0;
         dout_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, datapath update and registered status outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      dout_d  = dout_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               dout_d  = din;
               mode_d  = mode;
               cnt_d   = shamt;
               state_d = (shamt != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            dout_d = shift_step(dout_q, mode_q);
            cnt_d  = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dout = dout_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: arithmetic reference model checked every cycle plus directed literal cases.
module tb_seq_shift_unit;
   localparam int unsigned W  = 8;
   localparam int unsigned SW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  din = '0;
   logic [1:0]    mode = '0;
   logic [SW-1:0] shamt = '0;
   logic          busy, done;
   logic [W-1:0]  dout;

   int errors = 0;
   int checks = 0;

   seq_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .din(din), .mode(mode),
      .shamt(shamt), .busy(busy), .done(done), .dout(dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole shift by s positions at once, from the mode definitions.
   function automatic logic [W-1:0] shf(input logic [W-1:0] v, input logic [1:0] m, input int s);
      case (m)
         2'b00: return W'(v << s);
         2'b01: return W'(v >> s);
         2'b10: return W'($signed(v) >>> s);
         default: begin
`ifdef SEQ_SHIFT_ROTATE_EN
            return W'((v >> s) | (v << (W - s)));
`else
            return W'(v >> s);
`endif
         end
      endcase
   endfunction

   // Reference model: operation described by elapsed edges since acceptance.
   bit           m_active;
   int           m_k, m_sh;
   logic [W-1:0] m_din, m_last;
   logic [1:0]   m_mode;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_k = 0; m_sh = 0; m_last = '0; m_din = '0; m_mode = '0;
      end else if (m_active) begin
         if (m_k == m_sh) begin
            m_active = 0;
            m_last   = shf(m_din, m_mode, m_sh);
         end else m_k++;
      end else if (start) begin
         m_active = 1; m_k = 0; m_sh = int'(shamt); m_din = din; m_mode = mode;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_active) begin
            chk("model_busy", 32'(busy), 32'd1);
            chk("model_done", 32'(done), 32'(m_k == m_sh));
            chk("model_dout", 32'(dout), 32'(shf(m_din, m_mode, m_k)));
         end else begin
            chk("model_busy", 32'(busy), 32'd0);
            chk("model_done", 32'(done), 32'd0);
            chk("model_dout", 32'(dout), 32'(m_last));
         end
      end
   end

   // Issue one operation, wait for done (bounded), check result and latency.
   task automatic op(input string name, input logic [W-1:0] d, input logic [1:0] m,
                     input logic [SW-1:0] s, input logic [W-1:0] exp);
      int c;
      @(posedge clk); #1;
      start = 1'b1; din = d; mode = m; shamt = s;
      @(posedge clk); #1;
      start = 1'b0; din = ~d; mode = ~m; shamt = ~s;
      c = 1;
      @(negedge clk);
      while (!done && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk({name, "_lat"}, 32'(c), 32'(int'(s) + 1));
      chk({name, "_dout"}, 32'(dout), 32'(exp));
      @(posedge clk); #1;
      chk({name, "_idle_busy"}, 32'(busy), 32'd0);
      chk({name, "_idle_dout"}, 32'(dout), 32'(exp));
   endtask

   initial begin
      int c;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;

      op("lsl_06_3", 8'h06, 2'b00, 3'd3, 8'h30);
      op("asr_90_2", 8'h90, 2'b10, 3'd2, 8'hE4);
      op("lsr_90_2", 8'h90, 2'b01, 3'd2, 8'h24);
      op("lsl_ff_7", 8'hFF, 2'b00, 3'd7, 8'h80);
      op("asr_7f_7", 8'h7F, 2'b10, 3'd7, 8'h00);
      op("asr_80_7", 8'h80, 2'b10, 3'd7, 8'hFF);
      for (int m = 0; m < 4; m++) op("zero_a5", 8'hA5, 2'(m), 3'd0, 8'hA5);
`ifdef SEQ_SHIFT_ROTATE_EN
      op("m11_81_1", 8'h81, 2'b11, 3'd1, 8'hC0);
      op("m11_b4_5", 8'hB4, 2'b11, 3'd5, 8'hA5);
`else
      op("m11_81_1", 8'h81, 2'b11, 3'd1, 8'h40);
      op("m11_b4_5", 8'hB4, 2'b11, 3'd5, 8'h05);
`endif

      // start pulses during SHIFT and DONE must be ignored
      @(posedge clk); #1;
      start = 1'b1; din = 8'h06; mode = 2'b00; shamt = 3'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; din = 8'hFF; mode = 2'b01; shamt = 3'd1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      @(negedge clk);
      while (!done && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("ign_done_seen", 32'(done), 32'd1);
      chk("ign_dout", 32'(dout), 32'h30);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("ign_after_done_busy", 32'(busy), 32'd0);
      chk("ign_after_done_done", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("ign_hold_dout", 32'(dout), 32'h30);
      chk("ign_hold_busy", 32'(busy), 32'd0);

      // asynchronous reset in the middle of a shift
      @(posedge clk); #1;
      start = 1'b1; din = 8'h01; mode = 2'b00; shamt = 3'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("pre_rst_dout", 32'(dout), 32'h04);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_dout", 32'(dout), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_dout", 32'(dout), 32'd0);
      op("after_rst", 8'h01, 2'b00, 3'd1, 8'h02);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
